pa_arbiter: RTL

//  Round-robin arbiter/sequencer for the play-area (PA) bank register in regdecode.

---
 rtl/pa_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pa_arbiter.sv
// rtl/pa_arbiter.sv - round-robin arbiter for the shared play-area bank register
// Writes regdecode's PA ahead of each grant and keeps a shadow of the value it holds.
module pa_arbiter #(
  parameter int NREQ     = 4,
  parameter int PA_W     = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*PA_W-1:0] req_pa,
  input  logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      grant,
  output logic [PA_W:0]        set_pa,
  output logic [PA_W-1:0]      cur_pa,
  output logic                 busy,
  output logic                 timeout
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HC_W  = $clog2(MAX_HOLD);
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NREQ - 1);
  localparam logic [HC_W-1:0]  HC_LAST = HC_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_SWITCH, S_GRANT} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  win_q, win_d;
  logic [PA_W-1:0]   win_pa_q, win_pa_d;
  logic [PA_W-1:0]   cur_pa_q, cur_pa_d;
  logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;

  logic              any_req;
  logic [PTR_W-1:0]  cand;
  logic [PTR_W-1:0]  pick;
  logic [PA_W-1:0]   pick_pa;

  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return PTR_W'(s);
  endfunction

  // First active request after the last grantee, wrapping around.
  always_comb begin
    any_req = 1'b0;
    cand    = '0;
    pick    = ptr_q;
    pick_pa = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = rr_idx(ptr_q, i);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        pick    = cand;
        pick_pa = req_pa[cand*PA_W +: PA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    win_pa_d   = win_pa_q;
    cur_pa_d   = cur_pa_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      S_INIT: state_d = S_IDLE;
      S_IDLE: begin
        if (any_req) begin
          win_d      = pick;
          win_pa_d   = pick_pa;
          hold_cnt_d = '0;
          state_d    = (pick_pa == cur_pa_q) ? S_GRANT : S_SWITCH;
        end
      end
      S_SWITCH: begin
        cur_pa_d   = win_pa_q;
        hold_cnt_d = '0;
        state_d    = S_GRANT;
      end
      S_GRANT: begin
        // done has priority over the hold limit, so no timeout pulse then
        if (done[win_q] || !req[win_q]) begin
          ptr_d   = win_q;
          state_d = S_IDLE;
        end else if (hold_cnt_q == HC_LAST) begin
          ptr_d     = win_q;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      ptr_q      <= PTR_RST;
      win_q      <= '0;
      win_pa_q   <= '0;
      cur_pa_q   <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      win_pa_q   <= win_pa_d;
      cur_pa_q   <= cur_pa_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // regdecode's PA has no reset, so INIT (and reset itself) forces a write of 0.
  always_comb begin
    set_pa = '0;
    case (state_q)
      S_INIT:   set_pa = {1'b1, {PA_W{1'b0}}};
      S_SWITCH: set_pa = {1'b1, win_pa_q};
      default:  set_pa = '0;
    endcase
  end

  always_comb begin
    grant = '0;
    if (state_q == S_GRANT) grant[win_q] = 1'b1;
  end

  assign cur_pa  = cur_pa_q;
  assign busy    = (state_q != S_IDLE);
  assign timeout = timeout_q;

endmodule
